// File: rtl/npc_ctrl_pkg.sv
// npc_ctrl_pkg: shared types and constants for the NPC step controller and the
// decode LUT (state enum, halt codes, micro command layout and field values).
package npc_ctrl_pkg;

  localparam int MICRO_LEN = 13;

  // Micro command bit positions
  localparam int B_REGEN   = 12;
  localparam int B_PCJEN   = 11;
  localparam int B_PCREN   = 10;
  localparam int B_MWEN_HI = 9;
  localparam int B_MWEN_LO = 8;
  localparam int B_MREN_HI = 7;
  localparam int B_MREN_LO = 6;
  localparam int B_ALU_HI  = 5;
  localparam int B_ALU_LO  = 3;
  localparam int B_IMM_HI  = 2;
  localparam int B_IMM_LO  = 0;

  // Same layout as the bit positions above, MSB first
  typedef struct packed {
    logic       regen;
    logic       pcjen;
    logic       pcren;
    logic [1:0] mwen;
    logic [1:0] mren;
    logic [2:0] aluop;
    logic [2:0] imm_type;
  } micro_t;

  // MWEN / MREN encodings (also the LSU access size)
  localparam logic [1:0] MSZ_NONE = 2'b00;
  localparam logic [1:0] MSZ_B    = 2'b01;
  localparam logic [1:0] MSZ_H    = 2'b10;
  localparam logic [1:0] MSZ_W    = 2'b11;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_SLL  = 3'd6;
  localparam logic [2:0] ALU_SRL  = 3'd7;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_IWAIT  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_MWAIT  = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    HC_EBREAK  = 2'd0,
    HC_ILLEGAL = 2'd1,
    HC_TIMEOUT = 2'd2
  } halt_code_e;

endpackage

// File: rtl/npc_wdt.sv
// npc_wdt: wait-state watchdog counter.
//   clr     - zero the count (state entry)
//   en      - count this cycle
//   expired - LIMIT cycles have been spent since the last clear
module npc_wdt #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // cnt holds the number of cycles already spent, so the LIMIT-th cycle sees LIMIT-1
  assign expired = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (en && !expired)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/npc_step_ctrl.sv
// npc_step_ctrl: multi-cycle NPC control FSM, one instruction at a time:
// FETCH -> IWAIT -> DECODE -> [MEM -> MWAIT] -> WB, sticky HALT on ebreak,
// illegal instruction or (with NPC_MEM_TIMEOUT_EN) a wait-state timeout.
// Ports: IFU req/rsp handshake + inst_latch_en; decode LUT micro_cmd/hit/is_ebreak;
// LSU req/rsp handshake with lsu_we/lsu_size; rf_we/pc_we/pc_sel_jump strobes;
// registered alu_op/imm_type/pc_as_src; halt_valid/halt_code; retire_cnt; state_o.
// Build option: NPC_MEM_TIMEOUT_EN enables the npc_wdt wait-state watchdog.
module npc_step_ctrl
  import npc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ifu_req_valid,
  input  logic                 ifu_req_ready,
  input  logic                 ifu_rsp_valid,
  output logic                 inst_latch_en,
  input  logic [MICRO_LEN-1:0] micro_cmd,
  input  logic                 hit,
  input  logic                 is_ebreak,
  output logic                 lsu_req_valid,
  input  logic                 lsu_req_ready,
  output logic                 lsu_we,
  output logic [1:0]           lsu_size,
  input  logic                 lsu_rsp_valid,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic                 pc_sel_jump,
  output logic [2:0]           alu_op,
  output logic [2:0]           imm_type,
  output logic                 pc_as_src,
  output logic                 halt_valid,
  output logic [1:0]           halt_code,
  output logic [31:0]          retire_cnt,
  output logic [2:0]           state_o
);

  state_e      state, state_d;
  micro_t      mc, micro_q;
  logic [1:0]  hcode_q, hcode_d;
  logic [31:0] retire_q;
  logic        tmo;

  assign mc = micro_t'(micro_cmd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_FETCH;
      micro_q  <= '0;
      hcode_q  <= '0;
      retire_q <= '0;
    end else begin
      state   <= state_d;
      hcode_q <= hcode_d;
      if (state == ST_DECODE) micro_q  <= mc;
      if (state == ST_WB)     retire_q <= retire_q + 32'd1;
    end
  end

  always_comb begin
    state_d       = state;
    hcode_d       = hcode_q;
    ifu_req_valid = 1'b0;
    inst_latch_en = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_we        = 1'b0;
    lsu_size      = 2'b00;
    rf_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel_jump   = 1'b0;
    case (state)
      ST_FETCH: begin
        // state sits at FETCH during reset; keep the request quiet until released
        ifu_req_valid = ~rst;
        if (ifu_req_ready) state_d = ST_IWAIT;
      end
      ST_IWAIT: begin
        if (ifu_rsp_valid) begin
          inst_latch_en = 1'b1;
          state_d       = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!hit) begin
          state_d = ST_HALT;
          hcode_d = HC_ILLEGAL;
        end else if (is_ebreak) begin
          state_d = ST_HALT;
          hcode_d = HC_EBREAK;
        end else if ((mc.mwen != 2'b00) && (mc.mren != 2'b00)) begin
          state_d = ST_HALT;
          hcode_d = HC_ILLEGAL;
        end else if ((mc.mwen | mc.mren) != 2'b00) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        lsu_req_valid = 1'b1;
        lsu_we        = |micro_q.mwen;
        lsu_size      = micro_q.mwen | micro_q.mren;
        if (lsu_req_ready) state_d = ST_MWAIT;
      end
      ST_MWAIT: begin
        if (lsu_rsp_valid) state_d = ST_WB;
      end
      ST_WB: begin
        rf_we       = micro_q.regen;
        pc_we       = 1'b1;
        pc_sel_jump = micro_q.pcjen;
        state_d     = ST_FETCH;
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
    if (tmo) begin
      state_d = ST_HALT;
      hcode_d = HC_TIMEOUT;
    end
  end

`ifdef NPC_MEM_TIMEOUT_EN
  logic in_wait, wdt_clr, wdt_exp;

  assign in_wait = state inside {ST_FETCH, ST_IWAIT, ST_MEM, ST_MWAIT};
  // any state change clears, so every wait state starts counting from zero
  assign wdt_clr = (state_d != state);
  assign tmo     = in_wait & wdt_exp;

  npc_wdt #(.LIMIT(TIMEOUT_CYCLES)) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clr     (wdt_clr),
    .en      (in_wait),
    .expired (wdt_exp)
  );
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo        = 1'b0;
`endif

  assign alu_op     = micro_q.aluop;
  assign imm_type   = micro_q.imm_type;
  assign pc_as_src  = micro_q.pcren;
  assign halt_valid = (state == ST_HALT);
  assign halt_code  = hcode_q;
  assign retire_cnt = retire_q;
  assign state_o    = state;

endmodule

// File: tb/tb_npc_step_ctrl.sv
// tb_npc_step_ctrl: directed + randomized bench for npc_step_ctrl. A per-instruction
// model derives the expected state walk, strobes, LSU fields, halt code, latency
// and retire count from the instruction class and the chosen handshake delays.
module tb_npc_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, inst_latch_en;
  logic [12:0] micro_cmd;
  logic        hit, is_ebreak;
  logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid;
  logic [1:0]  lsu_size;
  logic        rf_we, pc_we, pc_sel_jump, pc_as_src, halt_valid;
  logic [2:0]  alu_op, imm_type, state_o;
  logic [1:0]  halt_code;
  logic [31:0] retire_cnt;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] exp_ret  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  npc_step_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .inst_latch_en(inst_latch_en),
    .micro_cmd(micro_cmd), .hit(hit), .is_ebreak(is_ebreak),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_we(lsu_we), .lsu_size(lsu_size), .lsu_rsp_valid(lsu_rsp_valid),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel_jump(pc_sel_jump),
    .alu_op(alu_op), .imm_type(imm_type), .pc_as_src(pc_as_src),
    .halt_valid(halt_valid), .halt_code(halt_code),
    .retire_cnt(retire_cnt), .state_o(state_o)
  );

  // state numbering of the debug port
  localparam logic [2:0] S_FETCH = 3'd0, S_IWAIT = 3'd1, S_DEC = 3'd2, S_MEM = 3'd3;
  localparam logic [2:0] S_MWAIT = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] mk(input bit regen, pcjen, pcren, input logic [1:0] mwen,
                                     input logic [1:0] mren, input logic [2:0] alu, imm);
    return {regen, pcjen, pcren, mwen, mren, alu, imm};
  endfunction

  task automatic clear_inputs();
    ifu_req_ready = 0; ifu_rsp_valid = 0; micro_cmd = '0; hit = 0; is_ebreak = 0;
    lsu_req_ready = 0; lsu_rsp_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; clear_inputs();
    @(negedge clk);
    @(negedge clk); rst = 0;
    exp_ret = 0;
  endtask

  // Runs one instruction from FETCH; rw/iw/mw/dw are extra wait cycles before
  // ifu_req_ready, ifu_rsp_valid, lsu_req_ready and lsu_rsp_valid respectively.
  task automatic do_instr(input logic [12:0] mc, input bit h, e, input int rw, iw, mw, dw);
    int c0;
    logic [1:0] mwen, mren, code;
    bit halts, mem;
    mwen = mc[9:8]; mren = mc[7:6];
    halts = 1; code = 2'd1; mem = 0;
    if (!h)                          code = 2'd1;
    else if (e)                      code = 2'd0;
    else if (mwen != 0 && mren != 0) code = 2'd1;
    else begin halts = 0; mem = (mwen != 0) || (mren != 0); end

    for (int i = 0; i <= rw; i++) begin
      @(negedge clk);
      if (i == 0) begin c0 = cyc; chk("fetch_retire", retire_cnt, exp_ret); end
      chk("fetch_state", state_o, S_FETCH);
      chk("fetch_req", ifu_req_valid, 1);
      chk("fetch_pcwe", pc_we, 0);
      ifu_req_ready = (i == rw);
    end
    for (int i = 0; i <= iw; i++) begin
      @(negedge clk);
      ifu_req_ready = 0; ifu_rsp_valid = (i == iw);
      #1;
      chk("iwait_state", state_o, S_IWAIT);
      chk("iwait_req", ifu_req_valid, 0);
      chk("iwait_latch", inst_latch_en, (i == iw));
    end
    @(negedge clk);
    ifu_rsp_valid = 0; micro_cmd = mc; hit = h; is_ebreak = e;
    chk("dec_state", state_o, S_DEC);
    chk("dec_latch", inst_latch_en, 0);

    if (halts) begin
      @(negedge clk);
      chk("halt_state", state_o, S_HALT);
      chk("halt_valid", halt_valid, 1);
      chk("halt_code", halt_code, code);
      ifu_req_ready = 1; ifu_rsp_valid = 1; lsu_req_ready = 1; lsu_rsp_valid = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk("halt_noreq", ifu_req_valid | lsu_req_valid | pc_we, 0);
        chk("halt_sticky", {halt_valid, halt_code}, {1'b1, code});
      end
      clear_inputs();
      return;
    end

    if (mem) begin
      for (int i = 0; i <= mw; i++) begin
        @(negedge clk);
        chk("mem_state", state_o, S_MEM);
        chk("mem_req", lsu_req_valid, 1);
        chk("mem_we", lsu_we, (mwen != 0));
        chk("mem_size", lsu_size, (mwen != 0) ? mwen : mren);
        chk("mem_alu", {alu_op, imm_type, pc_as_src}, {mc[5:3], mc[2:0], mc[10]});
        lsu_req_ready = (i == mw);
      end
      for (int i = 0; i <= dw; i++) begin
        @(negedge clk);
        lsu_req_ready = 0; lsu_rsp_valid = (i == dw);
        chk("mwait_state", state_o, S_MWAIT);
        chk("mwait_req", lsu_req_valid, 0);
      end
    end

    @(negedge clk);
    lsu_rsp_valid = 0;
    chk("wb_state", state_o, S_WB);
    chk("wb_rfwe", rf_we, mc[12]);
    chk("wb_pcwe", pc_we, 1);
    chk("wb_jump", pc_sel_jump, mc[11]);
    chk("wb_fields", {alu_op, imm_type, pc_as_src}, {mc[5:3], mc[2:0], mc[10]});
    exp_ret = exp_ret + 32'd1;
    @(negedge clk);
    chk("post_state", state_o, S_FETCH);
    chk("post_retire", retire_cnt, exp_ret);
    chk("latency", cyc - c0, 4 + rw + iw + (mem ? 2 + mw + dw : 0));
  endtask

  function automatic logic [12:0] rnd_micro();
    logic [1:0] mw, mr, sz;
    mw = 0; mr = 0;
    sz = 2'($urandom_range(1, 3));
    case ($urandom_range(0, 2))
      1:       mr = sz;
      2:       mw = sz;
      default: ;
    endcase
    return mk(1'($urandom), 1'($urandom), 1'($urandom), mw, mr,
              3'($urandom), 3'($urandom));
  endfunction

  localparam logic [1:0] NZ = 2'b00;

  initial begin
    logic [12:0] addi, lw, sb, jal, ebrk, ldst;
    addi = mk(1, 0, 0, NZ, NZ, 3'd0, 3'd1);
    lw   = mk(1, 0, 0, NZ, 2'b11, 3'd0, 3'd1);
    sb   = mk(0, 0, 0, 2'b01, NZ, 3'd0, 3'd2);
    jal  = mk(1, 1, 1, NZ, NZ, 3'd0, 3'd5);
    ebrk = '0;
    ldst = mk(1, 0, 0, 2'b10, 2'b11, 3'd0, 3'd1);
    clear_inputs();

    // reset state
    @(negedge clk);
    chk("rst_state", state_o, S_FETCH);
    chk("rst_outs", {ifu_req_valid, inst_latch_en, lsu_req_valid, rf_we, pc_we, halt_valid}, 0);
    chk("rst_fields", {alu_op, imm_type, pc_as_src, lsu_size, halt_code}, 0);
    chk("rst_retire", retire_cnt, 0);
    @(negedge clk); rst = 0;

    // directed instructions
    do_instr(addi, 1, 0, 0, 0, 0, 0);
    do_instr(lw,   1, 0, 0, 0, 3, 1);
    do_instr(sb,   1, 0, 1, 2, 0, 0);
    do_instr(jal,  1, 0, 0, 0, 0, 0);

    // randomized legal instructions and handshake delays
    for (int n = 0; n < 40; n++)
      do_instr(rnd_micro(), 1, 0, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3));

    // reset mid-MWAIT, then a stray LSU response while in FETCH
    @(negedge clk); ifu_req_ready = 1;
    @(negedge clk); ifu_req_ready = 0; ifu_rsp_valid = 1;
    @(negedge clk); ifu_rsp_valid = 0; micro_cmd = lw; hit = 1; is_ebreak = 0;
    @(negedge clk); lsu_req_ready = 1;
    @(negedge clk); lsu_req_ready = 0;
    chk("pre_rst_mwait", state_o, S_MWAIT);
    rst = 1;
    #1;
    chk("midrst_state", state_o, S_FETCH);
    chk("midrst_retire", retire_cnt, 0);
    chk("midrst_outs", {ifu_req_valid, lsu_req_valid, pc_we, alu_op}, 0);
    @(negedge clk); rst = 0; lsu_rsp_valid = 1;
    exp_ret = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_rsp_state", state_o, S_FETCH);
      chk("stray_rsp_wb", {pc_we, rf_we}, 0);
      chk("stray_rsp_retire", retire_cnt, 0);
    end
    lsu_rsp_valid = 0;

    // retire counter wrap via a preload of the counter register
    force dut.retire_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retire_q;
    exp_ret = 32'hFFFF_FFFF;
    do_instr(addi, 1, 0, 0, 0, 0, 0);
    chk("wrap_zero", retire_cnt, 32'h0);

    // halts: no hit, ebreak, load+store together
    do_reset();
    do_instr(addi, 0, 0, 0, 0, 0, 0);
    do_reset();
    do_instr(ebrk, 1, 1, 0, 1, 0, 0);
    do_reset();
    do_instr(ldst, 1, 0, 0, 0, 0, 0);
    do_reset();
    do_instr(addi, 0, 1, 0, 0, 0, 0);

`ifdef NPC_MEM_TIMEOUT_EN
    // IFU never ready: eight FETCH cycles, then timeout halt
    do_reset();
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("tmo_wait", state_o, S_FETCH);
    end
    @(negedge clk);
    chk("tmo_state", state_o, S_HALT);
    chk("tmo_code", halt_code, 2'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
